zicntr_csr_reader: RTL
======================

# zicntr_csr_reader

Read-side counterpart of the Zicntr counter control logic. Owns the 64-bit cycle/time/instret counter state and services CSR read requests from the computational stage over a valid/ready handshake, returning the counter value or an illegal-access flag one cycle after acceptance. Sits between the CSR decode in stage 3 and the writeback path.

## Interface
- `XLEN`, 32, architectural register width; only 32 or 64 are legal.

- `clk`  input  1  core clock, all state on rising edge
- `reset`  input  1  asynchronous, active-low; 0 clears all state immediately
- `InstructionRetired`  input  1  one instruction retired this cycle
- `CsrReq`  input  1  read request valid
- `CsrAddr`  input  12  CSR address of request
- `CsrWrite`  input  1  request carries a write (csrrw/csrrs with rs1≠x0, etc.)
- `CsrReady`  output  1  request accepted this cycle when `CsrReq && CsrReady`
- `RspValid`  output  1  response held in output register
- `RspReady`  input  1  consumer takes response when `RspValid && RspReady`
- `RspData`  output  XLEN  counter value, 0 when `RspIllegal`
- `RspIllegal`  output  1  illegal-instruction indication for the response

## Operation
- Counters: `cycle` (64 b) +1 every cycle out of reset; `time` aliases `cycle`; `instret` (64 b) + `InstructionRetired` each cycle. Both wrap 2^64−1 → 0.
- Address map: 0xC00 cycle, 0xC01 time, 0xC02 instret, 0xB02 minstret (= instret). XLEN=32 only: 0xC80, 0xC81, 0xC82, 0xB82 return bits [63:32] of the same counters; low addresses return [31:0]. XLEN=64: full 64 b; high addresses illegal.
- Illegal: unmapped address, or `CsrWrite`=1 to any mapped address (all read-only, including minstret). Illegal response: `RspIllegal`=1, `RspData`=0; counters unaffected.
- Read value = counter register value in the acceptance cycle (pre-increment; the retire in that same cycle is not included).
- Single-entry output register; no internal queue.

## Timing
- Reset values: `RspValid`=0, `RspData`=0, `RspIllegal`=0, `cycle`=0, `instret`=0, snapshot state cleared; `CsrReady`=1 immediately after reset.
- `CsrReady` = `!RspValid || RspReady` (combinational from `RspReady`).
- Latency: accept in cycle N → `RspValid`=1 with data in cycle N+1.
- Throughput: 1 read/cycle when `RspReady` held high (accept and drain in same cycle).
- Backpressure: `RspValid && !RspReady` holds `RspData`/`RspIllegal` stable, `CsrReady`=0; counters keep counting.
- First cycle after reset release: `cycle` reads 0.
- Reset mid-transaction: pending response discarded, `RspValid` drops asynchronously.

## Configuration
- `ZICNTR_HALF_SNAPSHOT_EN` (XLEN=32 only; ignored for XLEN=64).
- Defined: accepting a legal low-half read (0xC00/0xC01/0xC02/0xB02) latches bits [63:32] of that counter, at the same instant, into a 32 b snapshot tagged with the counter (time and cycle share a tag; instret and minstret share a tag). The next accepted read of the matching high address returns the snapshot and clears the tag; a non-matching high read returns the live value and leaves the tag. A new low read overwrites snapshot and tag. Illegal requests never touch snapshot.
- Undefined: high reads always return live bits [63:32]; no snapshot registers.

## Test plan
- Reset release, `RspReady`=1, read 0xC00 on cycle 3 → next cycle `RspValid`=1, `RspData`=3, `RspIllegal`=0.
- Pulse `InstructionRetired` 5 cycles, then read 0xC02 and 0xB02 back-to-back → both return 5, one response per cycle.
- `CsrWrite`=1 to 0xC01; separately read 0x123 → `RspIllegal`=1, `RspData`=0; XLEN=64 read of 0xC80 → illegal.
- `RspReady`=0 for 4 cycles after a read → `RspData` stable, `CsrReady`=0; raise `RspReady` → drained, next request accepted same cycle.
- XLEN=32, preload cycle to 0x0000_0000_FFFF_FFFE via forced count, read 0xC00 then 0xC80 two cycles later → with macro 0xFFFF_FFFE then 0x0000_0000; without macro 0xFFFF_FFFE then 0x0000_0001.
- Assert `reset`=0 while `RspValid`=1 → `RspValid`, counters go 0 without a clock edge.

Source files
------------

// File: rtl/zicntr_csr_reader.sv
// Zicntr cycle/time/instret counters with a read-only CSR port (valid/ready in, registered response out).
// Optional ZICNTR_HALF_SNAPSHOT_EN: XLEN=32 high-half reads return bits captured by the preceding low-half read.
module zicntr_csr_reader #(
  parameter int XLEN = 32  // 32 or 64 only
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            InstructionRetired,
  input  logic            CsrReq,
  input  logic [11:0]     CsrAddr,
  input  logic            CsrWrite,
  output logic            CsrReady,
  output logic            RspValid,
  input  logic            RspReady,
  output logic [XLEN-1:0] RspData,
  output logic            RspIllegal
);

  logic [63:0]     cycle_q, cycle_d;
  logic [63:0]     instret_q, instret_d;
  logic            rsp_valid_q, rsp_illegal_q;
  logic [XLEN-1:0] rsp_data_q;

  logic            hit, high, sel_instret, legal, accept;
  logic [63:0]     ctr;
  logic [XLEN-1:0] rd_value;

  assign CsrReady = !rsp_valid_q || RspReady;
  assign accept   = CsrReq && CsrReady;

  always_comb begin
    hit         = 1'b0;
    high        = 1'b0;
    sel_instret = 1'b0;
    case (CsrAddr)
      12'hC00, 12'hC01: hit = 1'b1;
      12'hC02, 12'hB02: begin
        hit         = 1'b1;
        sel_instret = 1'b1;
      end
      12'hC80, 12'hC81: if (XLEN == 32) begin
        hit  = 1'b1;
        high = 1'b1;
      end
      12'hC82, 12'hB82: if (XLEN == 32) begin
        hit         = 1'b1;
        high        = 1'b1;
        sel_instret = 1'b1;
      end
      default: ;
    endcase
  end

  // Every mapped counter is read-only, so any write attempt is illegal.
  assign legal = hit && !CsrWrite;
  assign ctr   = sel_instret ? instret_q : cycle_q;

`ifdef ZICNTR_HALF_SNAPSHOT_EN
  logic [31:0] snap_q;
  logic        snap_vld_q, snap_inst_q;
  logic        snap_hit;

  assign snap_hit = high && snap_vld_q && (snap_inst_q == sel_instret);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q      <= '0;
      snap_vld_q  <= 1'b0;
      snap_inst_q <= 1'b0;
    end else if (accept && legal && (XLEN == 32)) begin
      if (!high) begin
        snap_q      <= ctr[63:32];
        snap_vld_q  <= 1'b1;
        snap_inst_q <= sel_instret;
      end else if (snap_hit) begin
        snap_vld_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_value = ctr[XLEN-1:0];
    if (snap_hit)  rd_value = XLEN'(snap_q);
    else if (high) rd_value = XLEN'(ctr[63:32]);
  end
`else
  always_comb begin
    rd_value = ctr[XLEN-1:0];
    if (high) rd_value = XLEN'(ctr[63:32]);
  end
`endif

  assign cycle_d   = cycle_q + 64'd1;
  assign instret_d = instret_q + {63'd0, InstructionRetired};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // Accept and drain can coincide; a new accept simply overwrites the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_illegal_q <= 1'b0;
    end else if (accept) begin
      rsp_valid_q   <= 1'b1;
      rsp_data_q    <= legal ? rd_value : '0;
      rsp_illegal_q <= !legal;
    end else if (RspReady) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  assign RspValid   = rsp_valid_q;
  assign RspData    = rsp_data_q;
  assign RspIllegal = rsp_illegal_q;

endmodule
